// File: rtl/b8b10_enc_lanes.sv
// b8b10_enc_lanes: LANES-wide 8b/10b transmit encoder, running disparity chained lane 0 -> LANES-1 and across cycles.
// Optional macro B8B10_ENC_DISPINJ_EN adds disp_inj, which encodes lane 0 against the inverted registered rd.
module b8b10_enc_lanes #(
    parameter int unsigned LANES   = 2,
    parameter logic [7:0]  IDLE_K  = 8'hBC,
    parameter logic        RD_INIT = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*8-1:0]    in_data,
    input  logic [LANES-1:0]      in_k,
`ifdef B8B10_ENC_DISPINJ_EN
    input  logic                  disp_inj,
`endif
    output logic [LANES*10-1:0]   out_data,
    output logic                  out_valid,
    output logic                  out_idle,
    output logic [LANES-1:0]      kerr,
    output logic                  rd
);

    localparam int unsigned SW = LANES * 10;

    // 5b/6b code in abcdei order (a = MSB) as used at RD-; bit 6 set = complement at RD+
    function automatic logic [6:0] enc_6b(input logic [4:0] x, input logic k);
        logic [6:0] r;
        case (x)
            5'd0:    r = {1'b1, 6'b100111};
            5'd1:    r = {1'b1, 6'b011101};
            5'd2:    r = {1'b1, 6'b101101};
            5'd3:    r = {1'b0, 6'b110001};
            5'd4:    r = {1'b1, 6'b110101};
            5'd5:    r = {1'b0, 6'b101001};
            5'd6:    r = {1'b0, 6'b011001};
            5'd7:    r = {1'b1, 6'b111000};
            5'd8:    r = {1'b1, 6'b111001};
            5'd9:    r = {1'b0, 6'b100101};
            5'd10:   r = {1'b0, 6'b010101};
            5'd11:   r = {1'b0, 6'b110100};
            5'd12:   r = {1'b0, 6'b001101};
            5'd13:   r = {1'b0, 6'b101100};
            5'd14:   r = {1'b0, 6'b011100};
            5'd15:   r = {1'b1, 6'b010111};
            5'd16:   r = {1'b1, 6'b011011};
            5'd17:   r = {1'b0, 6'b100011};
            5'd18:   r = {1'b0, 6'b010011};
            5'd19:   r = {1'b0, 6'b110010};
            5'd20:   r = {1'b0, 6'b001011};
            5'd21:   r = {1'b0, 6'b101010};
            5'd22:   r = {1'b0, 6'b011010};
            5'd23:   r = {1'b1, 6'b111010};
            5'd24:   r = {1'b1, 6'b110011};
            5'd25:   r = {1'b0, 6'b100110};
            5'd26:   r = {1'b0, 6'b010110};
            5'd27:   r = {1'b1, 6'b110110};
            5'd28:   r = k ? {1'b1, 6'b001111} : {1'b0, 6'b001110};
            5'd29:   r = {1'b1, 6'b101110};
            5'd30:   r = {1'b1, 6'b011110};
            default: r = {1'b1, 6'b101011};
        endcase
        return r;
    endfunction

    // 3b/4b code in fghj order (f = MSB) as used at RD-; bit 4 set = complement at RD+
    function automatic logic [4:0] enc_4b(input logic [2:0] y, input logic k, input logic a7);
        logic [4:0] r;
        case (y)
            3'd0:    r = {1'b1, 4'b1011};
            3'd1:    r = k ? {1'b1, 4'b0110} : {1'b0, 4'b1001};
            3'd2:    r = k ? {1'b1, 4'b1010} : {1'b0, 4'b0101};
            3'd3:    r = {1'b1, 4'b1100};
            3'd4:    r = {1'b1, 4'b1101};
            3'd5:    r = k ? {1'b1, 4'b0101} : {1'b0, 4'b1010};
            3'd6:    r = k ? {1'b1, 4'b1001} : {1'b0, 4'b0110};
            default: r = (k | a7) ? {1'b1, 4'b0111} : {1'b1, 4'b1110};
        endcase
        return r;
    endfunction

    function automatic logic k_legal(input logic [7:0] b);
        logic [4:0] x;
        x = b[4:0];
        return (x == 5'd28) |
               ((b[7:5] == 3'd7) & ((x == 5'd23) | (x == 5'd27) | (x == 5'd29) | (x == 5'd30)));
    endfunction

    // Returns {rd_out, symbol} with symbol in {j,h,g,f,i,e,d,c,b,a} order
    function automatic logic [10:0] enc_sym(input logic [7:0] b, input logic k, input logic rd_in);
        logic [4:0] x;
        logic [2:0] y;
        logic [6:0] r6;
        logic [4:0] r4;
        logic [5:0] c6;
        logic [3:0] c4;
        logic       rd_mid;
        logic       rd_out;
        logic       a7;
        logic [9:0] abc;
        logic [9:0] sym;
        x      = b[4:0];
        y      = b[7:5];
        r6     = enc_6b(x, k);
        c6     = (r6[6] & rd_in) ? ~r6[5:0] : r6[5:0];
        rd_mid = rd_in ^ (r6[6] & (r6[5:0] != 6'b111000));
        a7     = ~k & (rd_mid ? ((x == 5'd11) | (x == 5'd13) | (x == 5'd14))
                              : ((x == 5'd17) | (x == 5'd18) | (x == 5'd20)));
        r4     = enc_4b(y, k, a7);
        c4     = (r4[4] & rd_mid) ? ~r4[3:0] : r4[3:0];
        rd_out = rd_mid ^ ((y == 3'd0) | (y == 3'd4) | (y == 3'd7));
        abc    = {c6, c4};
        for (int j = 0; j < 10; j++) begin
            sym[j] = abc[9 - j];
        end
        return {rd_out, sym};
    endfunction

    logic inj;
`ifdef B8B10_ENC_DISPINJ_EN
    assign inj = disp_inj;
`else
    assign inj = 1'b0;
`endif

    assign in_ready = en & ~reset;

    logic [LANES:0]   rd_chain;
    logic [SW-1:0]    sym_c;
    logic [LANES-1:0] kerr_c;
    logic [10:0]      enc_r;
    logic [7:0]       lane_b;
    logic             lane_k;

    // Lane encode chain; illegal K codes fall back to IDLE_K and keep the RD chain going
    always_comb begin
        rd_chain    = '0;
        sym_c       = '0;
        kerr_c      = '0;
        enc_r       = '0;
        lane_b      = '0;
        lane_k      = 1'b0;
        rd_chain[0] = rd ^ inj;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_b = in_valid ? in_data[8*i +: 8] : IDLE_K;
            lane_k = in_valid ? in_k[i] : 1'b1;
            if (lane_k && !k_legal(lane_b)) begin
                lane_b    = IDLE_K;
                kerr_c[i] = 1'b1;
            end
            enc_r              = enc_sym(lane_b, lane_k, rd_chain[i]);
            sym_c[10*i +: 10]  = enc_r[9:0];
            rd_chain[i+1]      = enc_r[10];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_idle  <= 1'b0;
            kerr      <= '0;
            rd        <= RD_INIT;
        end else if (en) begin
            out_data  <= sym_c;
            out_valid <= 1'b1;
            out_idle  <= ~in_valid;
            kerr      <= kerr_c;
            rd        <= rd_chain[LANES];
        end else begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_idle  <= 1'b0;
            kerr      <= '0;
        end
    end

endmodule

// File: doc/b8b10_enc_lanes.md
Name: b8b10_enc_lanes

Overview:
Parametrised multi-lane 8b/10b transmit encoder. It is the successor to the single-byte PHY TX encoder.
- Encodes LANES bytes per clock, with running disparity (RD) chained across lanes and across cycles.
- Supports K-characters and flags illegal K codes.
- Inserts idle commas when no data is offered.
- Sits between the TX framing logic and the serializer.

Parameters:
LANES, 2, bytes encoded per clock (1..8); lane 0 is transmitted first.
IDLE_K, 8'hBC, K-code emitted on every lane during idle (default K28.5).
RD_INIT, 1'b0, RD value after reset (0 = RD-, 1 = RD+).

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
en  in  1  encoder enable; 0 = output forced to zero, state frozen.
in_valid  in  1  in_data/in_k carry a word.
in_ready  out  1  word accepted on an edge where in_valid & in_ready.
in_data  in  LANES*8  byte i at [8i+7:8i].
in_k  in  LANES  bit i = byte i is a control character.
out_data  out  LANES*10  symbol i at [10i+9:10i], bit order {j,h,g,f,i,e,d,c,b,a}.
out_valid  out  1  out_data holds a symbol set.
out_idle  out  1  current out_data is idle fill.
kerr  out  LANES  bit i = lane i was an illegal K code (replaced by IDLE_K).
rd  out  1  RD after the last lane of the current out_data.

Behaviour:
- Reset: out_data=0, out_valid=0, out_idle=0, kerr=0, rd=RD_INIT. Reset overrides en and in_valid. Reset mid-stream drops any word in flight; the first post-reset symbols are encoded from RD_INIT.
- in_ready = en & ~reset (combinational). There is no backpressure beyond en; the encoder streams at line rate.
- Latency: one register stage. A word accepted at edge t appears on out_data/out_valid from edge t until edge t+1.
- On each edge with en=1 and reset=0:
  - out_valid<=1.
  - If in_valid=1: encode in_data/in_k, out_idle<=0.
  - Else: every lane encodes IDLE_K with k=1, out_idle<=1.
- RD chain:
  - Lane 0 uses the registered rd.
  - Lane i uses the RD output of lane i-1, all within one cycle (combinational chain).
  - The lane LANES-1 RD output is registered into rd.
- Legal K codes: K28.0-K28.7, K23.7, K27.7, K29.7, K30.7.
  - An illegal K on lane i is encoded as IDLE_K (RD chain continues from that symbol) and sets kerr[i]=1 for that output cycle.
  - kerr is 0 for data bytes and for idle.
- Encoding follows standard IEEE 802.3 clause 36 tables:
  - 5b/6b then 3b/4b, with the A7/P7 alternate (D.x.A7) for x=17,18,20 at RD- and x=11,13,14 at RD+.
  - Neutral sub-blocks leave RD unchanged.
- en=0: out_data<=0, out_valid<=0, out_idle<=0, kerr<=0; rd holds. On en returning to 1, encoding resumes from the held rd.
- rd changes only on edges where out_valid is written to 1.

Optional Feature:
Macro B8B10_ENC_DISPINJ_EN.
- Defined:
  - Adds input port disp_inj (1 bit).
  - When disp_inj=1 on an encoding edge (data or idle), lane 0 is encoded using the inverse of the registered rd.
  - This creates a deliberate disparity error; lanes 1..LANES-1 and rd chain normally from that lane-0 result.
  - disp_inj is ignored when en=0 or reset=1.
- Not defined: the port is absent and the encoder always uses true RD.

Test Plan:
- LANES=1, reset, en=1, in_valid=0 for 2 cycles -> out_data 10'h17C then 10'h283; out_idle=1; rd toggles 0->1->0.
- LANES=1, rd=0, in_data=8'h00 k=0 -> out_data 10'h0B9, rd stays 0; then in_data=8'hB5 (D21.5) -> 10'h155, rd stays 0.
- LANES=2, rd=0, in_data={8'hBC,8'hBC}, in_k=2'b11 -> lane0 10'h17C, lane1 10'h283, rd=0 after the word.
- LANES=2, in_data lane0=8'h1C k=1 (K28.0), lane1=8'h3C k=1 (K28.1, legal) -> kerr=0; then lane1=8'h1F k=1 (K31.0, illegal) -> lane1 encoded as IDLE_K, kerr=2'b10.
- Stream data, drop en to 0 for 3 cycles -> out_data=0, out_valid=0, rd held; re-enable -> next symbol encoded from held rd. Assert reset mid-stream -> all outputs 0 next edge, rd=RD_INIT.
- With B8B10_ENC_DISPINJ_EN, LANES=1, rd=0, idle, disp_inj=1 for one cycle -> out_data 10'h283 (RD+ form), rd=0 afterwards; the monitor's disparity checker flags exactly one error.
